// File: rtl/iddr_test_pkg.sv
// ---------------------------------------------------------------------------
// iddr_test_pkg
//
// Shared definitions for the IDDRE1 loopback receive checker.
//
// Contents:
//    chk_state_t        checker FSM states (IDLE, SEARCH, LOCKED)
//    DEF_LOCK_THRESH    consecutive good increments needed to lock
//    DEF_UNLOCK_THRESH  consecutive mismatches in LOCKED that drop the lock
//    DEF_PIPE_LAT       clk cycles from transmitter enable to a fabric sample
//    next_pattern()     successor of a 2-bit pattern value, modulo 4
// ---------------------------------------------------------------------------
package iddr_test_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SEARCH = 2'd1,
      ST_LOCKED = 2'd2
   } chk_state_t;

   localparam int DEF_LOCK_THRESH   = 8;
   localparam int DEF_UNLOCK_THRESH = 4;
   localparam int DEF_PIPE_LAT      = 2;

   // The transmitter counts by one per enabled clock and wraps 3 -> 0,
   // so the 2-bit addition is allowed to overflow on purpose.
   function automatic logic [1:0] next_pattern(input logic [1:0] value);
      return value + 2'd1;
   endfunction

endpackage

// File: rtl/ddr_pattern_checker.sv
// ---------------------------------------------------------------------------
// ddr_pattern_checker
//
// All fabric-side logic of the receive checker: registers the captured
// pair, delays the transmitter enable to line up with the captured data,
// runs the IDLE/SEARCH/LOCKED tracker and keeps saturating statistics.
// It has no primitive dependencies so it can be simulated on its own.
//
// Ports:
//    clk          fabric clock
//    rst          synchronous, active-high reset
//    enable       enable shared with the transmitter counter
//    raw          captured pair {falling-phase bit, rising-phase bit}
//    clear_stats  one-cycle pulse that zeroes err_count and good_count
//    sample       registered captured pair
//    locked       high while the tracker is LOCKED
//    error_pulse  one-cycle pulse per mismatch seen while LOCKED
//    err_count    saturating count of mismatches while LOCKED
//    good_count   saturating count of matches while LOCKED
// ---------------------------------------------------------------------------
module ddr_pattern_checker
   import iddr_test_pkg::*;
#(
   parameter int PIPE_LAT      = DEF_PIPE_LAT,
   parameter int LOCK_THRESH   = DEF_LOCK_THRESH,
   parameter int UNLOCK_THRESH = DEF_UNLOCK_THRESH,
   parameter int ERR_W         = 16,
   parameter int CNT_W         = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic [1:0]       raw,
   input  logic             clear_stats,
   output logic [1:0]       sample,
   output logic             locked,
   output logic             error_pulse,
   output logic [ERR_W-1:0] err_count,
   output logic [CNT_W-1:0] good_count
);

   localparam int MW = $clog2(LOCK_THRESH + 1);
   localparam int CW = $clog2(UNLOCK_THRESH + 1);

   // Last run value before the next match completes the lock / unlock.
   localparam logic [MW-1:0] LOCK_LAST   = MW'(LOCK_THRESH - 1);
   localparam logic [CW-1:0] UNLOCK_LAST = CW'(UNLOCK_THRESH - 1);

   logic [1:0]          prev;
   logic [PIPE_LAT-1:0] en_d;
   logic                chk_en;
   logic                chk_prev;
   logic                do_check;
   logic                is_match;

   chk_state_t          state;
   chk_state_t          state_nx;
   logic [MW-1:0]       match_cnt;
   logic [MW-1:0]       match_nx;
   logic [CW-1:0]       consec_err;
   logic [CW-1:0]       consec_nx;
   logic                hit;
   logic                miss;

   assign chk_en = en_d[PIPE_LAT-1];

   // A pair is only judged when both it and its predecessor were produced
   // under an enabled transmitter; otherwise the counter may have frozen
   // between them and equal values would be flagged as errors.
   assign do_check = chk_en & chk_prev;
   assign is_match = (sample == next_pattern(prev));

   // Data path: captured pair, its predecessor and the delayed enable.
   always_ff @(posedge clk) begin
      if (rst) begin
         sample   <= 2'd0;
         prev     <= 2'd0;
         en_d     <= '0;
         chk_prev <= 1'b0;
      end else begin
         sample   <= raw;
         prev     <= sample;
         en_d[0]  <= enable;
         for (int i = 1; i < PIPE_LAT; i++) begin
            en_d[i] <= en_d[i-1];
         end
         chk_prev <= chk_en;
      end
   end

   // Tracker next state. Dropping enable always returns to IDLE and takes
   // priority over any judgement of samples still in flight, so a stopped
   // transmitter never produces counted errors. hit/miss only fire in
   // LOCKED and feed the statistics and the error pulse.
   always_comb begin
      state_nx  = state;
      match_nx  = match_cnt;
      consec_nx = consec_err;
      hit       = 1'b0;
      miss      = 1'b0;
      if (!enable) begin
         state_nx  = ST_IDLE;
         match_nx  = '0;
         consec_nx = '0;
      end else begin
         case (state)
            ST_IDLE: begin
               state_nx  = ST_SEARCH;
               match_nx  = '0;
               consec_nx = '0;
            end
            ST_SEARCH: begin
               if (do_check) begin
                  if (is_match) begin
                     if (match_cnt == LOCK_LAST) begin
                        state_nx = ST_LOCKED;
                        match_nx = '0;
                     end else begin
                        match_nx = match_cnt + 1'b1;
                     end
                  end else begin
                     match_nx = '0;
                  end
               end
            end
            ST_LOCKED: begin
               if (do_check) begin
                  if (is_match) begin
                     hit       = 1'b1;
                     consec_nx = '0;
                  end else begin
                     miss = 1'b1;
                     if (consec_err == UNLOCK_LAST) begin
                        state_nx  = ST_SEARCH;
                        match_nx  = '0;
                        consec_nx = '0;
                     end else begin
                        consec_nx = consec_err + 1'b1;
                     end
                  end
               end
            end
            default: begin
               state_nx  = ST_IDLE;
               match_nx  = '0;
               consec_nx = '0;
            end
         endcase
      end
   end

   // Tracker registers. locked decodes the next state so that it is high
   // in exactly the cycles where the state register holds LOCKED.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         match_cnt   <= '0;
         consec_err  <= '0;
         locked      <= 1'b0;
         error_pulse <= 1'b0;
      end else begin
         state       <= state_nx;
         match_cnt   <= match_nx;
         consec_err  <= consec_nx;
         locked      <= (state_nx == ST_LOCKED);
         error_pulse <= miss;
      end
   end

   // Statistics. Both counters stick at all-ones instead of wrapping, and
   // a clear request beats an increment arriving in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_count  <= '0;
         good_count <= '0;
      end else if (clear_stats) begin
         err_count  <= '0;
         good_count <= '0;
      end else begin
         if (miss && (err_count != '1)) begin
            err_count <= err_count + 1'b1;
         end
         if (hit && (good_count != '1)) begin
            good_count <= good_count + 1'b1;
         end
      end
   end

endmodule

// File: rtl/iddr_test_checker.sv
// ---------------------------------------------------------------------------
// iddr_test_checker
//
// Receive side of the ODDRE1 loopback test. The DDR pad signal is captured
// by an IDDRE1 in SAME_EDGE_PIPELINED mode (rising-phase bit on Q1,
// falling-phase bit on Q2, both presented together on the next rising
// edge), optionally phase-swapped, and handed to ddr_pattern_checker which
// verifies the 2-bit incrementing pattern.
//
// Ports:
//    clk          capture and fabric clock (IDDRE1 CB is its inverse)
//    rst          synchronous, active-high reset, also drives IDDRE1 R
//    enable       enable shared with the transmitter counter
//    ddr_in       pad input after the IBUF
//    clear_stats  one-cycle pulse that zeroes the statistics
//    sample       registered captured pair
//    locked       high while the checker is LOCKED
//    error_pulse  one-cycle pulse per mismatch while LOCKED
//    err_count    saturating mismatch count while LOCKED
//    good_count   saturating match count while LOCKED
// ---------------------------------------------------------------------------
module iddr_test_checker
   import iddr_test_pkg::*;
#(
   parameter int PIPE_LAT      = DEF_PIPE_LAT,
   parameter int LOCK_THRESH   = DEF_LOCK_THRESH,
   parameter int UNLOCK_THRESH = DEF_UNLOCK_THRESH,
   parameter int ERR_W         = 16,
   parameter int CNT_W         = 32,
   parameter int SWAP_PHASE    = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             ddr_in,
   input  logic             clear_stats,
   output logic [1:0]       sample,
   output logic             locked,
   output logic             error_pulse,
   output logic [ERR_W-1:0] err_count,
   output logic [CNT_W-1:0] good_count
);

   logic       q1;
   logic       q2;
   logic [1:0] raw;

`ifdef USE_UNISIM
   // Hard input DDR register in the IOB.
   IDDRE1 #(
      .DDR_CLK_EDGE   ("SAME_EDGE_PIPELINED"),
      .IS_CB_INVERTED (1'b0),
      .IS_C_INVERTED  (1'b0)
   ) iddr_inst (
      .Q1 (q1),
      .Q2 (q2),
      .C  (clk),
      .CB (~clk),
      .D  (ddr_in),
      .R  (rst)
   );
`else
   // Flop-level equivalent of the IDDRE1 in SAME_EDGE_PIPELINED mode for
   // builds without the unisim library: one capture flop per clock phase,
   // then a rising-edge stage that presents both phases together.
   logic rise_cap;
   logic fall_cap;

   always_ff @(posedge clk) begin
      if (rst) begin
         rise_cap <= 1'b0;
      end else begin
         rise_cap <= ddr_in;
      end
   end

   always_ff @(negedge clk) begin
      if (rst) begin
         fall_cap <= 1'b0;
      end else begin
         fall_cap <= ddr_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q1 <= 1'b0;
         q2 <= 1'b0;
      end else begin
         q1 <= rise_cap;
         q2 <= fall_cap;
      end
   end
`endif

   // The transmitter drives bit0 in the rising phase and bit1 in the
   // falling phase; SWAP_PHASE covers a board or clocking setup where the
   // two phases arrive the other way round.
   assign raw = (SWAP_PHASE != 0) ? {q1, q2} : {q2, q1};

   ddr_pattern_checker #(
      .PIPE_LAT      (PIPE_LAT),
      .LOCK_THRESH   (LOCK_THRESH),
      .UNLOCK_THRESH (UNLOCK_THRESH),
      .ERR_W         (ERR_W),
      .CNT_W         (CNT_W)
   ) checker_inst (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .raw         (raw),
      .clear_stats (clear_stats),
      .sample      (sample),
      .locked      (locked),
      .error_pulse (error_pulse),
      .err_count   (err_count),
      .good_count  (good_count)
   );

endmodule

// File: tb/tb_iddr_test_checker.sv
// ---------------------------------------------------------------------------
// tb_iddr_test_checker
//
// Plays the ODDRE1 transmitter into the pad input of iddr_test_checker and
// compares every registered output, every cycle, with a cycle model built
// directly from the pattern-checking rules. Narrow counters are used so
// both saturation limits are reached in a short run.
// ---------------------------------------------------------------------------
module tb_iddr_test_checker;

   localparam int ERR_W    = 5;
   localparam int CNT_W    = 8;
   localparam int ERR_MAX  = (1 << ERR_W) - 1;
   localparam int GOOD_MAX = (1 << CNT_W) - 1;
   localparam int LOCK_N   = 8;
   localparam int UNLOCK_N = 4;
   localparam int N        = 1600;
   localparam int SAT_LO   = 200;
   localparam int SAT_HI   = 360;

   logic             clk = 1'b0;
   logic             rst;
   logic             enable;
   logic             ddr_in;
   logic             clear_stats;
   logic [1:0]       sample;
   logic             locked;
   logic             error_pulse;
   logic [ERR_W-1:0] err_count;
   logic [CNT_W-1:0] good_count;

   // Per-cycle stimulus, indexed by the rising edge that consumes it.
   bit         en_a   [N];
   bit         rst_a  [N];
   bit         clr_a  [N];
   bit         hold_a [N];
   int         err_a  [N];
   logic [1:0] d_a    [N];

   int total_checks = 0;
   int bad_checks   = 0;

   // Reference model state.
   bit m_active;
   bit m_locked;
   bit m_pulse;
   int m_run;
   int m_misses;
   int m_err;
   int m_good;

   iddr_test_checker #(
      .PIPE_LAT      (2),
      .LOCK_THRESH   (LOCK_N),
      .UNLOCK_THRESH (UNLOCK_N),
      .ERR_W         (ERR_W),
      .CNT_W         (CNT_W),
      .SWAP_PHASE    (0)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .ddr_in      (ddr_in),
      .clear_stats (clear_stats),
      .sample      (sample),
      .locked      (locked),
      .error_pulse (error_pulse),
      .err_count   (err_count),
      .good_count  (good_count)
   );

   always #5 clk = ~clk;

   // One comparison: counted always, reported only when it disagrees.
   task automatic checkOutput(input string tag, input int cyc, input longint observed, input longint expected);
      total_checks++;
      if (observed != expected) begin
         bad_checks++;
         $display("[TB] FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, observed, expected);
      end
   endtask

   // Control inputs for edge n plus the rising-phase data bit.
   task automatic applyStimulus(input int n);
      rst         = rst_a[n];
      enable      = en_a[n];
      clear_stats = clr_a[n];
      ddr_in      = d_a[n][0];
   endtask

   // Reset history; cycles before the run count as reset.
   function automatic bit rst_at(input int k);
      if (k < 0) return 1'b1;
      return rst_a[k];
   endfunction

   // The pair captured in cycle k reaches the sample register two edges
   // later, and a reset at any of those edges wipes it.
   function automatic int exp_sample(input int k);
      if (rst_at(k) || rst_at(k - 1) || rst_at(k - 2)) return 0;
      return int'(d_a[k-2]);
   endfunction

   // Enable as seen by the checker after edge k (two cycles late).
   function automatic bit exp_chk(input int k);
      if (rst_at(k) || rst_at(k - 1)) return 1'b0;
      return en_a[k-1];
   endfunction

   function automatic bit exp_chk_prev(input int k);
      if (rst_at(k)) return 1'b0;
      return exp_chk(k - 1);
   endfunction

   // Advance the model across edge n using the values held after n-1.
   task automatic updateModel(input int n);
      bit judged;
      bit good_step;
      judged    = exp_chk(n - 1) && exp_chk_prev(n - 1);
      good_step = (exp_sample(n - 1) == ((exp_sample(n - 2) + 1) % 4));
      m_pulse   = 1'b0;
      if (rst_a[n]) begin
         m_active = 1'b0;
         m_locked = 1'b0;
         m_run    = 0;
         m_misses = 0;
         m_err    = 0;
         m_good   = 0;
      end else begin
         if (!en_a[n]) begin
            m_active = 1'b0;
            m_locked = 1'b0;
            m_run    = 0;
            m_misses = 0;
         end else if (!m_active) begin
            m_active = 1'b1;
         end else if (judged && !m_locked) begin
            m_run = good_step ? m_run + 1 : 0;
            if (m_run == LOCK_N) begin
               m_locked = 1'b1;
               m_run    = 0;
            end
         end else if (judged) begin
            if (good_step) begin
               m_good   = (m_good < GOOD_MAX) ? m_good + 1 : m_good;
               m_misses = 0;
            end else begin
               m_pulse  = 1'b1;
               m_err    = (m_err < ERR_MAX) ? m_err + 1 : m_err;
               m_misses = m_misses + 1;
               if (m_misses == UNLOCK_N) begin
                  m_locked = 1'b0;
                  m_misses = 0;
                  m_run    = 0;
               end
            end
         end
         if (clr_a[n]) begin
            m_err  = 0;
            m_good = 0;
         end
      end
   endtask

   // Build the directed scenarios followed by a randomized stretch, then
   // derive the transmitted pattern: the counter advances on each enabled
   // clock and freezes while enable is low.
   task automatic buildStimulus();
      int gap;
      int tx;
      int dv;
      int prev_d;
      for (int n = 0; n < N; n++) begin
         en_a[n]   = 1'b1;
         rst_a[n]  = 1'b0;
         clr_a[n]  = 1'b0;
         hold_a[n] = 1'b0;
         err_a[n]  = 0;
      end
      for (int n = 0; n < 3; n++) begin
         rst_a[n] = 1'b1;
         en_a[n]  = 1'b0;
      end
      err_a[60] = 1;
      for (int n = 80; n < 85; n++) hold_a[n] = 1'b1;
      for (int n = 120; n < 123; n++) en_a[n] = 1'b0;
      clr_a[342] = 1'b1;
      rst_a[705] = 1'b1;
      gap = 0;
      for (int n = 720; n < N; n++) begin
         if (gap > 0) begin
            en_a[n] = 1'b0;
            gap--;
         end else if ($urandom_range(0, 24) == 0) begin
            en_a[n] = 1'b0;
            gap = int'($urandom_range(0, 2));
         end
         if ($urandom_range(0, 11) == 0) err_a[n] = int'($urandom_range(1, 3));
         if ($urandom_range(0, 59) == 0) begin
            for (int k = n; k < n + 5 && k < N; k++) hold_a[k] = 1'b1;
         end
         if ($urandom_range(0, 39) == 0) clr_a[n] = 1'b1;
         if ($urandom_range(0, 299) == 0) rst_a[n] = 1'b1;
      end
      tx     = 0;
      prev_d = 0;
      for (int m = 0; m < N; m++) begin
         if (m + 1 < N && en_a[m+1]) tx = (tx + 1) % 4;
         if (m >= SAT_LO && m < SAT_HI) begin
            dv = (((m - SAT_LO) % 4) == 0) ? (prev_d + 1) % 4 : prev_d;
            tx = dv;
         end else if (hold_a[m] && m > 0) begin
            dv = prev_d;
         end else begin
            dv = (tx + err_a[m]) % 4;
         end
         d_a[m] = 2'(dv);
         prev_d = dv;
      end
   endtask

   initial begin
      m_active = 1'b0;
      m_locked = 1'b0;
      m_pulse  = 1'b0;
      m_run    = 0;
      m_misses = 0;
      m_err    = 0;
      m_good   = 0;
      buildStimulus();
      applyStimulus(0);
      for (int n = 0; n < N; n++) begin
         @(posedge clk);
         #1;
         updateModel(n);
         checkOutput("sample", n, longint'(sample), longint'(exp_sample(n)));
         checkOutput("locked", n, longint'(locked), longint'(m_locked));
         checkOutput("error_pulse", n, longint'(error_pulse), longint'(m_pulse));
         checkOutput("err_count", n, longint'(err_count), longint'(m_err));
         checkOutput("good_count", n, longint'(good_count), longint'(m_good));
         case (n)
            50: begin
               checkOutput("first_lock", n, longint'(locked), 1);
               checkOutput("no_err_clean", n, longint'(err_count), 0);
            end
            70: begin
               checkOutput("single_err_count", n, longint'(err_count), 2);
               checkOutput("single_err_locked", n, longint'(locked), 1);
            end
            87:  checkOutput("unlocked_after_run", n, longint'(locked), 0);
            95:  checkOutput("unlock_err_count", n, longint'(err_count), 6);
            121: checkOutput("gap_idle", n, longint'(locked), 0);
            150: begin
               checkOutput("relock_after_gap", n, longint'(locked), 1);
               checkOutput("gap_no_errors", n, longint'(err_count), 6);
            end
            330: checkOutput("err_saturated", n, longint'(err_count), ERR_MAX);
            342: checkOutput("clear_beats_incr", n, longint'(err_count), 0);
            700: checkOutput("good_saturated", n, longint'(good_count), GOOD_MAX);
            705: begin
               checkOutput("rst_locked", n, longint'(locked), 0);
               checkOutput("rst_err", n, longint'(err_count), 0);
               checkOutput("rst_good", n, longint'(good_count), 0);
               checkOutput("rst_sample", n, longint'(sample), 0);
            end
            default: ;
         endcase
         ddr_in = d_a[n][1];
         @(negedge clk);
         #1;
         if (n + 1 < N) applyStimulus(n + 1);
      end
      $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
      $finish;
   end

endmodule
